// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle between the datapath fetch/data ports, the arbiter and the
// SRAM-like bus bridge. The arbiter takes the slave view; the environment takes master.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_addr_ok;
    logic          i_data_ok;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_wr;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_addr_ok;
    logic          d_data_ok;
    logic [DW-1:0] d_rdata;

    logic          m_req;
    logic          m_wr;
    logic [1:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_addr_ok;
    logic          m_data_ok;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata,
        input  m_addr_ok, m_data_ok, m_rdata,
        output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
        output m_req, m_wr, m_size, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_size, d_addr, d_wdata,
        output m_addr_ok, m_data_ok, m_rdata,
        input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
        input  m_req, m_wr, m_size, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (fetch / data) arbiter onto one SRAM-like bus, one transaction in flight.
// Data side wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_bus_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_I,
        S_ADDR_D,
        S_DATA_I,
        S_DATA_D
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic arb_en;
    logic starved;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            starve_q <= '0;
            wr_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        wr_d          = wr_q;
        size_d        = size_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        bus.m_req     = 1'b0;
        bus.i_addr_ok = 1'b0;
        bus.d_addr_ok = 1'b0;
        bus.i_data_ok = 1'b0;
        bus.d_data_ok = 1'b0;

        case (state_q)
            S_ADDR_I: begin
                bus.m_req     = 1'b1;
                bus.i_addr_ok = bus.m_addr_ok;
                if (bus.m_addr_ok) state_d = S_DATA_I;
            end
            S_ADDR_D: begin
                bus.m_req     = 1'b1;
                bus.d_addr_ok = bus.m_addr_ok;
                if (bus.m_addr_ok) state_d = S_DATA_D;
            end
            S_DATA_I: bus.i_data_ok = bus.m_data_ok;
            S_DATA_D: bus.d_data_ok = bus.m_data_ok;
            default: ;
        endcase

        // Re-arbitrating on the response cycle gives back-to-back grants with no idle gap.
        arb_en  = (state_q == S_IDLE) ||
                  (((state_q == S_DATA_I) || (state_q == S_DATA_D)) && bus.m_data_ok);
        starved = (starve_q == SW'(STARVE_LIMIT));

        if (arb_en) begin
            if (bus.d_req && !(bus.i_req && starved)) begin
                state_d  = S_ADDR_D;
                wr_d     = bus.d_wr;
                size_d   = bus.d_size;
                addr_d   = bus.d_addr;
                wdata_d  = bus.d_wdata;
                starve_d = bus.i_req ? (starved ? starve_q : starve_q + 1'b1) : '0;
            end else if (bus.i_req) begin
                state_d  = S_ADDR_I;
                wr_d     = 1'b0;
                size_d   = 2'd2;
                addr_d   = bus.i_addr;
                wdata_d  = '0;
                starve_d = '0;
            end else begin
                state_d  = S_IDLE;
            end
        end
    end

    assign bus.m_wr    = wr_q;
    assign bus.m_size  = size_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.i_rdata = bus.m_rdata;
    assign bus.d_rdata = bus.m_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the grant / handshake rules.
module tb_mem_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

    mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Stimulus for the next cycle
    logic        dv_ireq, dv_dreq, dv_dwr, dv_maok, dv_mdok;
    logic [31:0] dv_iaddr, dv_daddr, dv_dwdata, dv_mrdata;
    logic [1:0]  dv_dsize;

    // Model: a granted-but-not-accepted request, and an accepted request awaiting its response
    typedef struct {
        bit        side_d;
        bit        wr;
        bit [1:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } txn_t;

    bit   g_valid;
    txn_t g_txn;
    bit   o_valid;
    bit   o_side_d;
    int   starve;
    bit   grant_log[$];
    bit   acc_i, acc_d;

    // Random agent state
    bit i_pend, d_pend;
    int bwait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".m_req"},     32'(bus_if.m_req),     32'h0);
        chk({tag, ".m_wr"},      32'(bus_if.m_wr),      32'h0);
        chk({tag, ".m_size"},    32'(bus_if.m_size),    32'h0);
        chk({tag, ".m_addr"},    bus_if.m_addr,         32'h0);
        chk({tag, ".m_wdata"},   bus_if.m_wdata,        32'h0);
        chk({tag, ".i_addr_ok"}, 32'(bus_if.i_addr_ok), 32'h0);
        chk({tag, ".d_addr_ok"}, 32'(bus_if.d_addr_ok), 32'h0);
        chk({tag, ".i_data_ok"}, 32'(bus_if.i_data_ok), 32'h0);
        chk({tag, ".d_data_ok"}, 32'(bus_if.d_data_ok), 32'h0);
    endtask

    task automatic model_reset();
        g_valid  = 1'b0;
        o_valid  = 1'b0;
        o_side_d = 1'b0;
        starve   = 0;
        i_pend   = 1'b0;
        d_pend   = 1'b0;
        bwait    = 0;
    endtask

    task automatic drive_idle();
        dv_ireq = 1'b0; dv_iaddr = '0;
        dv_dreq = 1'b0; dv_dwr = 1'b0; dv_dsize = '0; dv_daddr = '0; dv_dwdata = '0;
        dv_maok = 1'b0; dv_mdok = 1'b0; dv_mrdata = '0;
    endtask

    // Who wins when the bus is free: data, unless fetch has waited through LIM data grants
    task automatic arbitrate();
        if (dv_dreq && !(dv_ireq && starve == LIM)) begin
            g_txn.side_d = 1'b1; g_txn.wr = dv_dwr; g_txn.size = dv_dsize;
            g_txn.addr = dv_daddr; g_txn.wdata = dv_dwdata;
            starve = dv_ireq ? ((starve < LIM) ? starve + 1 : LIM) : 0;
            g_valid = 1'b1;
            grant_log.push_back(1'b1);
        end else if (dv_ireq) begin
            g_txn.side_d = 1'b0; g_txn.wr = 1'b0; g_txn.size = 2'd2;
            g_txn.addr = dv_iaddr; g_txn.wdata = '0;
            starve = 0;
            g_valid = 1'b1;
            grant_log.push_back(1'b0);
        end
    endtask

    // One clock: apply stimulus after the edge, check outputs, advance the model
    task automatic cyc();
        bit was_free, done;
        @(posedge clk);
        #1;
        bus_if.i_req     = dv_ireq;   bus_if.i_addr  = dv_iaddr;
        bus_if.d_req     = dv_dreq;   bus_if.d_wr    = dv_dwr;   bus_if.d_size = dv_dsize;
        bus_if.d_addr    = dv_daddr;  bus_if.d_wdata = dv_dwdata;
        bus_if.m_addr_ok = dv_maok;   bus_if.m_data_ok = dv_mdok; bus_if.m_rdata = dv_mrdata;
        #2;
        chk("m_req", 32'(bus_if.m_req), 32'(g_valid));
        if (g_valid) begin
            chk("m_addr",  bus_if.m_addr,         g_txn.addr);
            chk("m_wr",    32'(bus_if.m_wr),      32'(g_txn.wr));
            chk("m_size",  32'(bus_if.m_size),    32'(g_txn.size));
            chk("m_wdata", bus_if.m_wdata,        g_txn.wdata);
        end
        chk("i_addr_ok", 32'(bus_if.i_addr_ok), 32'(g_valid && !g_txn.side_d && dv_maok));
        chk("d_addr_ok", 32'(bus_if.d_addr_ok), 32'(g_valid &&  g_txn.side_d && dv_maok));
        chk("i_data_ok", 32'(bus_if.i_data_ok), 32'(o_valid && !o_side_d && dv_mdok));
        chk("d_data_ok", 32'(bus_if.d_data_ok), 32'(o_valid &&  o_side_d && dv_mdok));
        if (o_valid && dv_mdok) begin
            chk("i_rdata", bus_if.i_rdata, dv_mrdata);
            chk("d_rdata", bus_if.d_rdata, dv_mrdata);
        end

        acc_i = 1'b0;
        acc_d = 1'b0;
        was_free = !g_valid && !o_valid;
        done     = o_valid && dv_mdok;
        if (done) o_valid = 1'b0;
        if (g_valid && dv_maok) begin
            o_valid  = 1'b1;
            o_side_d = g_txn.side_d;
            acc_i    = !g_txn.side_d;
            acc_d    = g_txn.side_d;
            g_valid  = 1'b0;
        end
        if (was_free || done) arbitrate();
    endtask

    // Random requesters (hold req until accepted) and a bus with random waits
    task automatic rand_cycle(input int pi, input int pd, input int pa);
        if (!i_pend && $urandom_range(99) < 32'(pi)) begin
            i_pend   = 1'b1;
            dv_iaddr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_pend && $urandom_range(99) < 32'(pd)) begin
            d_pend    = 1'b1;
            dv_dwr    = 1'($urandom_range(1));
            dv_dsize  = 2'($urandom_range(2));
            dv_daddr  = $urandom;
            dv_dwdata = $urandom;
        end
        dv_ireq = i_pend;
        dv_dreq = d_pend;
        dv_maok = ($urandom_range(99) < 32'(pa));
        if (o_valid) begin
            if (bwait == 0) dv_mdok = 1'b1;
            else begin
                dv_mdok = 1'b0;
                bwait--;
            end
        end else begin
            dv_mdok = ($urandom_range(7) == 0);
        end
        dv_mrdata = $urandom;
        cyc();
        if (acc_i) i_pend = 1'b0;
        if (acc_d) d_pend = 1'b0;
        if (acc_i || acc_d) bwait = int'($urandom_range(2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        drive_idle();
        bus_if.i_req = 1'b0; bus_if.i_addr = '0; bus_if.d_req = 1'b0; bus_if.d_wr = 1'b0;
        bus_if.d_size = '0; bus_if.d_addr = '0; bus_if.d_wdata = '0;
        bus_if.m_addr_ok = 1'b0; bus_if.m_data_ok = 1'b0; bus_if.m_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        chk_zero("reset");
        reset = 1'b0;

        // Single fetch: addr_ok with m_req, response two cycles later
        dv_ireq = 1'b1; dv_iaddr = 32'hBFC0_0000; dv_maok = 1'b1;
        cyc();
        chk("fetch.cyc0_m_req", 32'(bus_if.m_req), 32'h0);
        cyc();
        chk("fetch.cyc1_m_req", 32'(bus_if.m_req), 32'h1);
        chk("fetch.cyc1_m_addr", bus_if.m_addr, 32'hBFC0_0000);
        chk("fetch.cyc1_i_addr_ok", 32'(bus_if.i_addr_ok), 32'h1);
        dv_ireq = 1'b0; dv_maok = 1'b0;
        cyc();
        dv_mdok = 1'b1; dv_mrdata = 32'h3C08_0001;
        cyc();
        chk("fetch.i_data_ok", 32'(bus_if.i_data_ok), 32'h1);
        chk("fetch.i_rdata", bus_if.i_rdata, 32'h3C08_0001);
        chk("fetch.d_data_ok", 32'(bus_if.d_data_ok), 32'h0);
        drive_idle();
        cyc();

        // Spurious responses in IDLE and ADDR_I, then both handshakes at once in ADDR_I
        dv_mdok = 1'b1;
        cyc();
        chk("spur.idle_i_data_ok", 32'(bus_if.i_data_ok), 32'h0);
        chk("spur.idle_d_data_ok", 32'(bus_if.d_data_ok), 32'h0);
        dv_ireq = 1'b1; dv_iaddr = 32'h0000_1230;
        cyc();
        cyc();
        chk("spur.addr_i_data_ok", 32'(bus_if.i_data_ok), 32'h0);
        cyc();
        chk("spur.still_addr_i", 32'(bus_if.m_req), 32'h1);
        dv_maok = 1'b1;
        cyc();
        dv_ireq = 1'b0; dv_maok = 1'b0; dv_mdok = 1'b0;
        cyc();
        dv_mdok = 1'b1; dv_mrdata = 32'h1234_5678;
        cyc();
        chk("spur.late_i_data_ok", 32'(bus_if.i_data_ok), 32'h1);
        drive_idle();
        cyc();

        // Byte write with addr_ok held off; live inputs changing must not leak onto the bus
        dv_dreq = 1'b1; dv_dwr = 1'b1; dv_dsize = 2'd0;
        dv_daddr = 32'h8000_1000; dv_dwdata = 32'h0000_00AB;
        cyc();
        dv_daddr = 32'h0; dv_dwdata = 32'hFFFF_FFFF; dv_dsize = 2'd2;
        for (int k = 1; k <= 3; k++) begin
            dv_maok = (k == 3);
            cyc();
            chk("wr.m_addr", bus_if.m_addr, 32'h8000_1000);
            chk("wr.m_wdata", bus_if.m_wdata, 32'h0000_00AB);
            chk("wr.d_addr_ok", 32'(bus_if.d_addr_ok), 32'(k == 3));
        end
        drive_idle();
        dv_mdok = 1'b1;
        cyc();
        chk("wr.d_data_ok", 32'(bus_if.d_data_ok), 32'h1);
        drive_idle();
        cyc();

        // Starvation: both requesting continuously from a cold start
        grant_log.delete();
        model_reset();
        for (int c = 0; c < 300 && grant_log.size() < 10; c++) rand_cycle(100, 100, 100);
        chk("starve.grants_seen", 32'(grant_log.size() >= 10), 32'h1);
        if (grant_log.size() >= 10) begin
            for (int g = 0; g < 10; g++)
                chk("starve.order", 32'(grant_log[g]), 32'((g != 4) && (g != 9)));
        end
        // Drain the in-flight transaction before the next scenario
        for (int c = 0; c < 20 && (g_valid || o_valid); c++) rand_cycle(0, 0, 100);
        chk("starve.drained", 32'(g_valid || o_valid), 32'h0);
        drive_idle();
        model_reset();
        cyc();

        // Reset while a data read waits for its response
        dv_dreq = 1'b1; dv_dwr = 1'b0; dv_dsize = 2'd2; dv_daddr = 32'h8000_2000;
        cyc();
        dv_maok = 1'b1;
        cyc();
        drive_idle();
        cyc();
        bus_if.m_data_ok = 1'b1;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        bus_if.m_data_ok = 1'b0;
        reset = 1'b0;
        dv_ireq = 1'b1; dv_iaddr = 32'h0040_0000; dv_maok = 1'b1;
        cyc();
        cyc();
        chk("postreset.m_addr", bus_if.m_addr, 32'h0040_0000);
        dv_ireq = 1'b0; dv_maok = 1'b0; dv_mdok = 1'b1; dv_mrdata = 32'hCAFE_0001;
        cyc();
        chk("postreset.i_data_ok", 32'(bus_if.i_data_ok), 32'h1);
        drive_idle();
        cyc();

        // Random mixed traffic
        model_reset();
        for (int c = 0; c < 2000; c++) rand_cycle(40, 40, 50);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
